// File: rtl/alu_issue_ctrl.sv
// ----------------------------------------------------------------------------
// alu_issue_ctrl
//
// Issue controller for the shared 32-bit ALU. NREQ requesters compete for
// the ALU, and only one operation is in flight at any time. The winner's
// operands and opcode are latched onto the ALU inputs for one cycle (EXEC).
// The controller then waits out the ALU's registered latency (CAPT) and
// captures the result and the [S,Z,N,V,C] flags. It returns them over a
// valid/ready response channel (RESP).
//
// An illegal opcode never reaches the ALU. It goes straight to RESP with
// rsp_err set and a zero result and zero flags.
//
// Build option:
//   ALU_ARB_FIXED_PRI_EN - when defined, the lowest requester index always
//                          wins and no round-robin pointer exists. When
//                          undefined, the arbiter is round-robin: the search
//                          starts one index after the previous winner.
// ----------------------------------------------------------------------------
module alu_issue_ctrl #(
    parameter int NREQ = 2,
    parameter int IDW  = 2
) (
    input  logic                 clkout,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [NREQ*32-1:0]   req_a,
    input  logic [NREQ*32-1:0]   req_b,
    input  logic [NREQ*6-1:0]    req_op,
    output logic [31:0]          alu_a,
    output logic [31:0]          alu_b,
    output logic [5:0]           alu_opcode,
    input  logic [31:0]          alu_result,
    input  logic [4:0]           alu_flags,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [IDW-1:0]       rsp_id,
    output logic [31:0]          rsp_result,
    output logic [4:0]           rsp_flags,
    output logic                 rsp_err,
    output logic                 busy
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_EXEC = 2'b01,
        ST_CAPT = 2'b10,
        ST_RESP = 2'b11
    } state_t;

    // Opcode legality: groups 001 and 010 carry the two-operand forms,
    // and group 011 is fully populated.
    function automatic logic op_is_legal(input logic [5:0] op);
        logic ok;
        case (op[5:3])
            3'b001:  ok = (op[2:0] != 3'b000);
            3'b010:  ok = (op[2:0] != 3'b000) && (op[2:0] != 3'b111);
            3'b011:  ok = 1'b1;
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

    state_t            state_r;
    state_t            state_s;

    logic              grant_any_s;
    logic [IDW-1:0]    grant_idx_s;
    logic [NREQ-1:0]   grant_oh_s;
    logic [31:0]       sel_a_s;
    logic [31:0]       sel_b_s;
    logic [5:0]        sel_op_s;
    logic              sel_legal_s;

    logic [31:0]       alu_a_r;
    logic [31:0]       alu_b_r;
    logic [5:0]        alu_op_r;
    logic              rsp_valid_r;
    logic [IDW-1:0]    rsp_id_r;
    logic [31:0]       rsp_result_r;
    logic [4:0]        rsp_flags_r;
    logic              rsp_err_r;

`ifndef ALU_ARB_FIXED_PRI_EN
    logic [IDW-1:0]    rr_ptr_r;
`endif

    // Arbitration: the winner is the valid requester closest to the start of
    // the search order (rr_ptr+1 upward with wrap, or index 0 when fixed).
    always_comb begin
        int best_v;
        int dist_v;
        grant_any_s = 1'b0;
        grant_idx_s = '0;
        grant_oh_s  = '0;
        best_v      = NREQ;
        dist_v      = 0;
        for (int i = 0; i < NREQ; i++) begin
`ifdef ALU_ARB_FIXED_PRI_EN
            dist_v = i;
`else
            dist_v = (i + NREQ - 1 - int'(rr_ptr_r)) % NREQ;
`endif
            if (req_valid[i] && (dist_v < best_v)) begin
                best_v      = dist_v;
                grant_idx_s = IDW'(i);
                grant_any_s = 1'b1;
            end else begin
                best_v      = best_v;
            end
        end
        for (int i = 0; i < NREQ; i++) begin
            grant_oh_s[i] = grant_any_s && (grant_idx_s == IDW'(i));
        end
    end

    // Payload mux: AND-OR select of the granted requester's operands/opcode.
    always_comb begin
        sel_a_s  = 32'h0000_0000;
        sel_b_s  = 32'h0000_0000;
        sel_op_s = 6'b000000;
        for (int i = 0; i < NREQ; i++) begin
            sel_a_s  = sel_a_s  | ({32{grant_oh_s[i]}} & req_a[32*i +: 32]);
            sel_b_s  = sel_b_s  | ({32{grant_oh_s[i]}} & req_b[32*i +: 32]);
            sel_op_s = sel_op_s | ({6{grant_oh_s[i]}}  & req_op[6*i +: 6]);
        end
        sel_legal_s = op_is_legal(sel_op_s);
    end

    // Next-state logic for the single-operation issue sequence.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (grant_any_s) begin
                    if (sel_legal_s) begin
                        state_s = ST_EXEC;
                    end else begin
                        state_s = ST_RESP;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_EXEC: state_s = ST_CAPT;
            ST_CAPT: state_s = ST_RESP;
            ST_RESP: begin
                if (rsp_ready) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_RESP;
                end
            end
            default: state_s = ST_IDLE;
        endcase
    end

    // State register; reset drops any in-flight operation.
    always_ff @(posedge clkout or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

`ifndef ALU_ARB_FIXED_PRI_EN
    // Round-robin pointer remembers the last winner; reset makes index 0 first.
    always_ff @(posedge clkout or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_r <= IDW'(NREQ - 1);
        end else if ((state_r == ST_IDLE) && grant_any_s) begin
            rr_ptr_r <= grant_idx_s;
        end else begin
            rr_ptr_r <= rr_ptr_r;
        end
    end
`endif

    // Registered ALU drive and response datapath.
    always_ff @(posedge clkout or negedge rst_n) begin
        if (!rst_n) begin
            alu_a_r      <= 32'h0000_0000;
            alu_b_r      <= 32'h0000_0000;
            alu_op_r     <= 6'b000000;
            rsp_valid_r  <= 1'b0;
            rsp_id_r     <= '0;
            rsp_result_r <= 32'h0000_0000;
            rsp_flags_r  <= 5'b00000;
            rsp_err_r    <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (grant_any_s) begin
                        rsp_id_r <= grant_idx_s;
                        if (sel_legal_s) begin
                            // Present the operation to the ALU for the EXEC cycle.
                            alu_a_r  <= sel_a_s;
                            alu_b_r  <= sel_b_s;
                            alu_op_r <= sel_op_s;
                        end else begin
                            // Illegal opcode: the ALU is left untouched.
                            rsp_result_r <= 32'h0000_0000;
                            rsp_flags_r  <= 5'b00000;
                            rsp_err_r    <= 1'b1;
                            rsp_valid_r  <= 1'b1;
                        end
                    end else begin
                        rsp_valid_r <= 1'b0;
                    end
                end
                ST_EXEC: begin
                    // ALU samples at the end of EXEC, so return to no-op for CAPT.
                    alu_op_r <= 6'b000000;
                end
                ST_CAPT: begin
                    rsp_result_r <= alu_result;
                    rsp_flags_r  <= alu_flags;
                    rsp_err_r    <= 1'b0;
                    rsp_valid_r  <= 1'b1;
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_r <= 1'b0;
                    end else begin
                        rsp_valid_r <= 1'b1;
                    end
                end
                default: begin
                    rsp_valid_r <= 1'b0;
                    alu_op_r    <= 6'b000000;
                end
            endcase
        end
    end

    assign req_ready  = (state_r == ST_IDLE) ? grant_oh_s : {NREQ{1'b0}};
    assign busy       = (state_r != ST_IDLE);
    assign alu_a      = alu_a_r;
    assign alu_b      = alu_b_r;
    assign alu_opcode = alu_op_r;
    assign rsp_valid  = rsp_valid_r;
    assign rsp_id     = rsp_id_r;
    assign rsp_result = rsp_result_r;
    assign rsp_flags  = rsp_flags_r;
    assign rsp_err    = rsp_err_r;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// ----------------------------------------------------------------------------
// Testbench for alu_issue_ctrl.
// The bench contains a small registered ALU stand-in and a transaction-level
// reference model. The model tracks who holds the ALU, how many cycles have
// passed since the grant, and what the response must be. A negedge compare
// process checks every DUT output against that model on every cycle. Directed
// sequences pin the model with hand-computed literals. A randomized phase
// follows the directed sequences.
// ----------------------------------------------------------------------------
module tb_alu_issue_ctrl;
    localparam int NREQ = 2;
    localparam int IDW  = 2;
    localparam logic [5:0] LEGAL_OPS [21] = '{
        6'o11, 6'o12, 6'o13, 6'o14, 6'o15, 6'o16, 6'o17,
        6'o21, 6'o22, 6'o23, 6'o24, 6'o25, 6'o26,
        6'o30, 6'o31, 6'o32, 6'o33, 6'o34, 6'o35, 6'o36, 6'o37};

    logic                clkout = 1'b0;
    logic                rst_n  = 1'b0;
    logic [NREQ-1:0]     req_valid, req_ready;
    logic [NREQ*32-1:0]  req_a, req_b;
    logic [NREQ*6-1:0]   req_op;
    logic [31:0]         alu_a, alu_b, alu_result;
    logic [5:0]          alu_opcode;
    logic [4:0]          alu_flags;
    logic                rsp_valid, rsp_ready, rsp_err, busy;
    logic [IDW-1:0]      rsp_id;
    logic [31:0]         rsp_result;
    logic [4:0]          rsp_flags;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    // Model state: m_age = cycles since grant (-1 when idle).
    int          m_age, m_id, m_last, m_gnt;
    bit          m_legal, m_rspv, m_err;
    logic [5:0]  m_op;
    logic [31:0] m_res, m_alua, m_alub;
    logic [4:0]  m_flg;

    alu_issue_ctrl #(.NREQ(NREQ), .IDW(IDW)) dut (
        .clkout(clkout), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_op(req_op),
        .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode),
        .alu_result(alu_result), .alu_flags(alu_flags),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_result(rsp_result), .rsp_flags(rsp_flags), .rsp_err(rsp_err),
        .busy(busy)
    );

    always #5 clkout = ~clkout;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ALU behaviour used by the stand-in: returns {S,Z,N,V,C,result}.
    function automatic logic [36:0] alu_fn(input logic [31:0] a, input logic [31:0] b,
                                          input logic [5:0] op);
        logic [32:0] w;
        logic [31:0] r;
        logic        v, c;
        v = 1'b0;
        c = 1'b0;
        if (op == 6'o11) begin
            w = {1'b0, a} + {1'b0, b};
            r = w[31:0];
            c = w[32];
            v = (a[31] == b[31]) && (r[31] != a[31]);
        end else if (op == 6'o12) begin
            w = {1'b0, a} - {1'b0, b};
            r = w[31:0];
            c = w[32];
            v = (a[31] != b[31]) && (r[31] != a[31]);
        end else begin
            r = (a ^ {b[15:0], b[31:16]}) + {26'd0, op};
        end
        return {^r, (r == 32'd0), r[31], v, c, r};
    endfunction

    // Registered ALU stand-in: the result appears one cycle after sampling.
    always @(posedge clkout) {alu_flags, alu_result} <= alu_fn(alu_a, alu_b, alu_opcode);

    function automatic bit is_legal_m(input logic [5:0] op);
        for (int k = 0; k < 21; k++) if (LEGAL_OPS[k] == op) return 1'b1;
        return 1'b0;
    endfunction

    function automatic int m_winner(input logic [NREQ-1:0] v);
`ifdef ALU_ARB_FIXED_PRI_EN
        for (int k = 0; k < NREQ; k++) if (v[k]) return k;
`else
        for (int k = 1; k <= NREQ; k++) if (v[(m_last + k) % NREQ]) return (m_last + k) % NREQ;
`endif
        return -1;
    endfunction

    task automatic model_reset();
        m_age = -1; m_rspv = 1'b0; m_last = NREQ - 1; m_gnt = -1;
        m_alua = 32'd0; m_alub = 32'd0; m_op = 6'd0; m_legal = 1'b0;
        m_id = 0; m_err = 1'b0; m_res = 32'd0; m_flg = 5'd0;
    endtask

    // Advance the model across one rising edge using the inputs held at that edge.
    task automatic model_step();
        int w;
        m_gnt = -1;
        if (!rst_n) begin
            model_reset();
        end else if (m_age < 0) begin
            w = m_winner(req_valid);
            if (w >= 0) begin
                m_gnt = w; m_age = 1; m_id = w;
                m_op = req_op[6*w +: 6];
                m_legal = is_legal_m(m_op);
`ifndef ALU_ARB_FIXED_PRI_EN
                m_last = w;
`endif
                if (m_legal) begin
                    m_alua = req_a[32*w +: 32];
                    m_alub = req_b[32*w +: 32];
                    {m_flg, m_res} = alu_fn(m_alua, m_alub, m_op);
                    m_err = 1'b0; m_rspv = 1'b0;
                end else begin
                    m_res = 32'd0; m_flg = 5'd0; m_err = 1'b1; m_rspv = 1'b1;
                end
            end
        end else if (m_rspv) begin
            if (rsp_ready) begin
                m_age = -1; m_rspv = 1'b0;
            end
        end else begin
            m_age++;
            if (m_age >= 3) m_rspv = 1'b1;
        end
    endtask

    // Per-cycle comparison of every output against the model.
    always @(negedge clkout) begin : cmp
        int w;
        logic [NREQ-1:0] er;
        if (chk_en && rst_n) begin
            w  = m_winner(req_valid);
            er = '0;
            if (m_age < 0 && w >= 0) er[w] = 1'b1;
            chk("busy", busy, (m_age >= 0));
            chk("req_ready", req_ready, er);
            chk("rsp_valid", rsp_valid, m_rspv);
            if (m_rspv) begin
                chk("rsp_id", rsp_id, m_id);
                chk("rsp_result", rsp_result, m_res);
                chk("rsp_flags", rsp_flags, m_flg);
                chk("rsp_err", rsp_err, m_err);
            end
            chk("alu_opcode", alu_opcode, (m_age == 1 && m_legal && !m_rspv) ? m_op : 6'd0);
            chk("alu_a", alu_a, m_alua);
            chk("alu_b", alu_b, m_alub);
        end
    end

    task automatic tick();
        @(posedge clkout);
        model_step();
        #1;
        if (m_gnt >= 0) req_valid[m_gnt] = 1'b0;
    endtask

    task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b,
                           input logic [5:0] op);
        req_a[32*i +: 32] = a;
        req_b[32*i +: 32] = b;
        req_op[6*i +: 6]  = op;
        req_valid[i]      = 1'b1;
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while ((m_age >= 0 || req_valid != '0) && n < 200) begin
            tick();
            n++;
        end
        if (n >= 200) begin
            checks++; errors++;
            $display("FAIL %s: timeout waiting for idle, busy=%0b", name, busy);
        end
    endtask

    function automatic logic [31:0] rand_operand();
        case ($urandom_range(0, 3))
            0:       return 32'h0000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            default: return $urandom;
        endcase
    endfunction

    function automatic logic [5:0] rand_op();
        if ($urandom_range(0, 3) == 0) return 6'($urandom_range(0, 63));
        return LEGAL_OPS[$urandom_range(0, 20)];
    endfunction

    int          gid[$];
    int          gcyc[$];
    logic [31:0] s_res;
    logic [4:0]  s_flg;
    logic [IDW-1:0] s_id;

    initial begin
        req_valid = '0; req_a = '0; req_b = '0; req_op = '0; rsp_ready = 1'b1;
        model_reset();
        chk_en = 1'b1;
        repeat (2) @(posedge clkout);
        @(negedge clkout);
        chk("rst_rsp_valid", rsp_valid, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_alu_opcode", alu_opcode, 6'b000000);
        chk("rst_alu_a", alu_a, 32'd0);
        chk("rst_rsp_result", rsp_result, 32'd0);
        chk("rst_rsp_err", rsp_err, 1'b0);
        #2 rst_n = 1'b1;
        tick();

        // ADD 5+7 from requester 0.
        set_req(0, 32'd5, 32'd7, 6'o11);
        @(negedge clkout);
        chk("add_ready", req_ready, 2'b01);
        tick(); tick(); tick();
        @(negedge clkout);
        chk("add_rsp_valid", rsp_valid, 1'b1);
        chk("add_result", rsp_result, 32'd12);
        chk("add_flags", rsp_flags, 5'b00000);
        chk("add_id", rsp_id, 2'd0);
        chk("add_err", rsp_err, 1'b0);
        tick();

        // SUB 3-3 from requester 1.
        set_req(1, 32'd3, 32'd3, 6'o12);
        @(negedge clkout);
        chk("sub_ready", req_ready, 2'b10);
        tick(); tick(); tick();
        @(negedge clkout);
        chk("sub_result", rsp_result, 32'd0);
        chk("sub_flags", rsp_flags, 5'b01000);
        chk("sub_id", rsp_id, 2'd1);
        tick();

        // Illegal opcode 000_111 from requester 0.
        set_req(0, 32'd9, 32'd9, 6'o07);
        @(negedge clkout);
        chk("ill_ready", req_ready, 2'b01);
        tick();
        @(negedge clkout);
        chk("ill_rsp_valid", rsp_valid, 1'b1);
        chk("ill_err", rsp_err, 1'b1);
        chk("ill_result", rsp_result, 32'd0);
        chk("ill_alu_opcode", alu_opcode, 6'b000000);
        tick();

        // Both requesters hold valid continuously.
        set_req(0, 32'd1, 32'd2, 6'o11);
        set_req(1, 32'd3, 32'd4, 6'o11);
        for (int c = 0; c < 16; c++) begin
            @(negedge clkout);
            if (req_ready[0]) begin gid.push_back(0); gcyc.push_back(c); end
            if (req_ready[1]) begin gid.push_back(1); gcyc.push_back(c); end
            tick();
            if (!req_valid[0]) set_req(0, 32'd1, 32'd2, 6'o11);
            if (!req_valid[1]) set_req(1, 32'd3, 32'd4, 6'o11);
        end
        req_valid = '0;
        chk("cont_grants", gid.size(), 4);
        for (int k = 0; k < gid.size(); k++) begin
            chk("cont_cycle", gcyc[k], 4 * k);
`ifdef ALU_ARB_FIXED_PRI_EN
            chk("cont_id", gid[k], 0);
`else
            chk("cont_id", gid[k], (k % 2 == 0) ? 1 : 0);
`endif
        end
        wait_idle("cont_drain");

        // Response back-pressure: rsp_ready low for 10 cycles.
        rsp_ready = 1'b0;
        set_req(0, 32'hFFFF_FFFF, 32'd1, 6'o11);
        tick();
        set_req(1, 32'd6, 32'd2, 6'o12);
        tick(); tick();
        @(negedge clkout);
        s_res = rsp_result; s_flg = rsp_flags; s_id = rsp_id;
        chk("stall_valid", rsp_valid, 1'b1);
        chk("stall_result", s_res, 32'd0);
        chk("stall_flags", s_flg, 5'b01001);
        for (int c = 0; c < 10; c++) begin
            tick();
            @(negedge clkout);
            chk("stall_hold_result", rsp_result, 32'd0);
            chk("stall_hold_flags", rsp_flags, 5'b01001);
            chk("stall_hold_id", rsp_id, 2'd0);
            chk("stall_ready", req_ready, 2'b00);
            chk("stall_busy", busy, 1'b1);
        end
        rsp_ready = 1'b1;
        tick();
        @(negedge clkout);
        chk("release_busy", busy, 1'b0);
        chk("release_ready", req_ready, 2'b10);
        wait_idle("stall_drain");

        // Reset while requester 1's operation is in EXEC.
        set_req(1, 32'd10, 32'd20, 6'o11);
        tick();
        #1 rst_n = 1'b0;
        model_reset();
        #1;
        chk("mid_rst_busy", busy, 1'b0);
        chk("mid_rst_alu_opcode", alu_opcode, 6'b000000);
        chk("mid_rst_alu_a", alu_a, 32'd0);
        chk("mid_rst_alu_b", alu_b, 32'd0);
        chk("mid_rst_rsp_valid", rsp_valid, 1'b0);
        chk("mid_rst_ready", req_ready, 2'b00);
        tick();
        #2 rst_n = 1'b1;
        set_req(0, 32'd100, 32'd1, 6'o12);
        set_req(1, 32'd200, 32'd2, 6'o11);
        @(negedge clkout);
        chk("post_rst_ready", req_ready, 2'b01);
        wait_idle("post_rst_drain");

        // Randomized traffic.
        for (int c = 0; c < 3000; c++) begin
            tick();
            for (int i = 0; i < NREQ; i++) begin
                if (!req_valid[i] && $urandom_range(0, 2) == 0)
                    set_req(i, rand_operand(), rand_operand(), rand_op());
            end
            rsp_ready = ($urandom_range(0, 3) != 0);
        end
        rsp_ready = 1'b1;
        wait_idle("final_drain");
        tick();
        @(negedge clkout);
        chk("final_busy", busy, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
